// File: rtl/writeback_arbiter_pkg.sv
// Shared core definitions for the writeback path: data width, register-number
// width, source-select encoding and a register-range helper.
package writeback_arbiter_pkg;

    localparam int CORE_XLEN = 32;
    localparam int REG_NUM_W = 6;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_sel_e;

    // True for a register that exists and is writable (not x0, below size).
    function automatic logic rd_writable(input logic [REG_NUM_W-1:0] rd, input int size);
        return (rd != '0) && (int'(rd) < size);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one saturating 2-bit counter per architectural
// register (x0 excluded), plus combinational busy lookups for two sources.
module wb_scoreboard
    import writeback_arbiter_pkg::*;
#(
    parameter int REG_FILE_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_en,
    input  logic [REG_NUM_W-1:0] inc_rd,
    input  logic                 dec_en,
    input  logic [REG_NUM_W-1:0] dec_rd,
    input  logic [REG_NUM_W-1:0] rs1_num,
    input  logic [REG_NUM_W-1:0] rs2_num,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 err_overflow
);

    logic [1:0]               r_cnt [1:REG_FILE_SIZE-1];
    logic                     r_err_overflow;
    logic                     w_inc_ok;
    logic [REG_FILE_SIZE-1:1] w_inc_hit;
    logic [REG_FILE_SIZE-1:1] w_dec_hit;
    logic                     w_rs1_busy;
    logic                     w_rs2_busy;

    assign w_inc_ok = inc_en && rd_writable(inc_rd, REG_FILE_SIZE);

    // Decode which counter (if any) is incremented and decremented this edge.
    always_comb begin
        w_inc_hit = '0;
        w_dec_hit = '0;
        for (int i = 1; i < REG_FILE_SIZE; i++) begin
            w_inc_hit[i] = w_inc_ok && (inc_rd == REG_NUM_W'(i));
            w_dec_hit[i] = dec_en && (dec_rd == REG_NUM_W'(i));
        end
    end

    // Counter update: coincident inc/dec cancel, inc saturates at 3 and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < REG_FILE_SIZE; i++) begin
                r_cnt[i] <= 2'd0;
            end
            r_err_overflow <= 1'b0;
        end else begin
            for (int i = 1; i < REG_FILE_SIZE; i++) begin
                if (w_inc_hit[i] && !w_dec_hit[i]) begin
                    if (r_cnt[i] == 2'd3) begin
                        r_err_overflow <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 2'd1;
                    end
                end else if (w_dec_hit[i] && !w_inc_hit[i] && (r_cnt[i] != 2'd0)) begin
                    r_cnt[i] <= r_cnt[i] - 2'd1;
                end
            end
        end
    end

    // Busy lookup; x0 and out-of-range numbers never match a counter.
    always_comb begin
        w_rs1_busy = 1'b0;
        w_rs2_busy = 1'b0;
        for (int i = 1; i < REG_FILE_SIZE; i++) begin
            if ((rs1_num == REG_NUM_W'(i)) && (r_cnt[i] != 2'd0)) w_rs1_busy = 1'b1;
            if ((rs2_num == REG_NUM_W'(i)) && (r_cnt[i] != 2'd0)) w_rs2_busy = 1'b1;
        end
    end

    assign rs1_busy     = w_rs1_busy;
    assign rs2_busy     = w_rs2_busy;
    assign err_overflow = r_err_overflow;

endmodule

// File: rtl/writeback_arbiter.sv
// Two-source writeback arbiter (ALU, LSU) with round-robin on contention,
// a registered register-file write port and a pending-write scoreboard.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int REG_FILE_SIZE = 32,
    parameter int XLEN          = CORE_XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_NUM_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [REG_NUM_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    input  logic                 issue_valid,
    input  logic [REG_NUM_W-1:0] issue_rd,
    input  logic [REG_NUM_W-1:0] rs1_num,
    input  logic [REG_NUM_W-1:0] rs2_num,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 wb_write_en,
    output logic [REG_NUM_W-1:0] wb_reg_num,
    output logic [XLEN-1:0]      wb_data,
    output logic                 err_bad_reg,
    output logic                 err_overflow
);

    // r_rr_ptr names the source that wins the next contended cycle.
    src_sel_e             r_rr_ptr;
    logic                 r_wb_write_en;
    logic [REG_NUM_W-1:0] r_wb_reg_num;
    logic [XLEN-1:0]      r_wb_data;
    logic                 r_err_bad_reg;

    logic                 w_contended;
    logic                 w_alu_ready;
    logic                 w_lsu_ready;
    logic                 w_accept;
    src_sel_e             w_grant_src;
    logic [REG_NUM_W-1:0] w_sel_rd;
    logic [XLEN-1:0]      w_sel_data;

    assign w_contended = alu_valid && lsu_valid;

    // Grant from valids and pointer only, so ready has no path from rd/data.
    always_comb begin
        w_alu_ready = 1'b0;
        w_lsu_ready = 1'b0;
        w_grant_src = SRC_ALU;
        if (!rst) begin
            if (w_contended) begin
                w_grant_src = r_rr_ptr;
                w_alu_ready = (r_rr_ptr == SRC_ALU);
                w_lsu_ready = (r_rr_ptr == SRC_LSU);
            end else if (alu_valid) begin
                w_grant_src = SRC_ALU;
                w_alu_ready = 1'b1;
            end else if (lsu_valid) begin
                w_grant_src = SRC_LSU;
                w_lsu_ready = 1'b1;
            end
        end
    end

    assign w_accept   = w_alu_ready || w_lsu_ready;
    assign w_sel_rd   = (w_grant_src == SRC_LSU) ? lsu_rd   : alu_rd;
    assign w_sel_data = (w_grant_src == SRC_LSU) ? lsu_data : alu_data;

    // Register the accepted result and update pointer and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= SRC_LSU;
            r_wb_write_en <= 1'b0;
            r_wb_reg_num  <= '0;
            r_wb_data     <= '0;
            r_err_bad_reg <= 1'b0;
        end else begin
            r_wb_write_en <= w_accept && rd_writable(w_sel_rd, REG_FILE_SIZE);
            if (w_accept) begin
                r_wb_reg_num <= w_sel_rd;
                r_wb_data    <= w_sel_data;
                if (int'(w_sel_rd) >= REG_FILE_SIZE) begin
                    r_err_bad_reg <= 1'b1;
                end
            end
            if (w_contended) begin
                r_rr_ptr <= (r_rr_ptr == SRC_ALU) ? SRC_LSU : SRC_ALU;
            end
        end
    end

    // Decrement is driven by the same registered write the register file
    // absorbs, so busy drops on the edge the new value lands.
    wb_scoreboard #(
        .REG_FILE_SIZE(REG_FILE_SIZE)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .inc_en       (issue_valid),
        .inc_rd       (issue_rd),
        .dec_en       (r_wb_write_en),
        .dec_rd       (r_wb_reg_num),
        .rs1_num      (rs1_num),
        .rs2_num      (rs2_num),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .err_overflow (err_overflow)
    );

    assign alu_ready   = w_alu_ready;
    assign lsu_ready   = w_lsu_ready;
    assign wb_write_en = r_wb_write_en;
    assign wb_reg_num  = r_wb_reg_num;
    assign wb_data     = r_wb_data;
    assign err_bad_reg = r_err_bad_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, a hand-written pointer
// sequence, then random traffic against a behavioural reference model.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int N = 32;
    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [5:0]    alu_rd, lsu_rd, issue_rd, rs1_num, rs2_num, wb_reg_num;
    logic [W-1:0]  alu_data, lsu_data, wb_data;
    logic          issue_valid, rs1_busy, rs2_busy, wb_write_en;
    logic          err_bad_reg, err_overflow;

    int n_checks = 0;
    int n_errors = 0;

    writeback_arbiter #(.REG_FILE_SIZE(N), .XLEN(W)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_num(rs1_num), .rs2_num(rs2_num), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wb_write_en(wb_write_en), .wb_reg_num(wb_reg_num), .wb_data(wb_data),
        .err_bad_reg(err_bad_reg), .err_overflow(err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vector: inputs for one cycle plus the outputs expected in it.
    typedef struct {
        logic [31:0] rst, av, ar, ad, lv, lr, ld, iv, ird, rs1, rs2;
        logic [31:0] e_ar, e_lr, e_wen, e_wreg, e_wdata, e_chk, e_b1, e_b2, e_bad, e_ovf;
    } vec_t;

    vec_t tbl [31];

    // Reference model state: what each register's pending count is, which
    // source wins the next tie, and what the write port shows this cycle.
    int          m_cnt [N];
    bit          m_pref_lsu;
    bit          m_wen;
    int          m_wreg;
    logic [31:0] m_wdata;
    bit          m_bad, m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit writable(input int r);
        return (r > 0) && (r < N);
    endfunction

    function automatic bit m_busy(input int r);
        return writable(r) && (m_cnt[r] != 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_pref_lsu = 1'b1;
        m_wen = 1'b0;
        m_wreg = 0;
        m_wdata = '0;
        m_bad = 1'b0;
        m_ovf = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_edge();
        bit acc_alu, acc_lsu, inc;
        int rd, ird;
        if (rst) begin
            model_reset();
            return;
        end
        acc_alu = alu_valid && (!lsu_valid || !m_pref_lsu);
        acc_lsu = lsu_valid && (!alu_valid || m_pref_lsu);
        ird = int'(issue_rd);
        inc = issue_valid && writable(ird);
        if (!(inc && m_wen && ird == m_wreg)) begin
            if (inc) begin
                if (m_cnt[ird] == 3) m_ovf = 1'b1;
                else m_cnt[ird]++;
            end
            if (m_wen && m_cnt[m_wreg] > 0) m_cnt[m_wreg]--;
        end
        if (alu_valid && lsu_valid) m_pref_lsu = acc_alu;
        if (acc_alu || acc_lsu) begin
            rd = acc_lsu ? int'(lsu_rd) : int'(alu_rd);
            m_wdata = acc_lsu ? lsu_data : alu_data;
            m_wreg = rd;
            m_wen = writable(rd);
            if (rd >= N) m_bad = 1'b1;
        end else begin
            m_wen = 1'b0;
        end
    endtask

    task automatic model_check(input string tag);
        check({tag, "_alu_ready"}, 32'(alu_ready),
              32'(!rst && alu_valid && (!lsu_valid || !m_pref_lsu)));
        check({tag, "_lsu_ready"}, 32'(lsu_ready),
              32'(!rst && lsu_valid && (!alu_valid || m_pref_lsu)));
        check({tag, "_wb_en"}, 32'(wb_write_en), 32'(m_wen));
        if (m_wen) begin
            check({tag, "_wb_reg"}, 32'(wb_reg_num), 32'(m_wreg));
            check({tag, "_wb_data"}, wb_data, m_wdata);
        end
        check({tag, "_rs1_busy"}, 32'(rs1_busy), 32'(m_busy(int'(rs1_num))));
        check({tag, "_rs2_busy"}, 32'(rs2_busy), 32'(m_busy(int'(rs2_num))));
        check({tag, "_err_bad"}, 32'(err_bad_reg), 32'(m_bad));
        check({tag, "_err_ovf"}, 32'(err_overflow), 32'(m_ovf));
    endtask

    task automatic drive_idle();
        rst = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1_num = '0; rs2_num = '0;
    endtask

    task automatic apply(input vec_t t);
        rst = t.rst[0]; alu_valid = t.av[0]; alu_rd = t.ar[5:0]; alu_data = t.ad;
        lsu_valid = t.lv[0]; lsu_rd = t.lr[5:0]; lsu_data = t.ld;
        issue_valid = t.iv[0]; issue_rd = t.ird[5:0]; rs1_num = t.rs1[5:0]; rs2_num = t.rs2[5:0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        //           rst av ar ad            lv lr ld     iv ird rs1 rs2   ar lr wen wreg wdata          chk b1 b2 bad ovf
        tbl[0]  = '{1, 1, 0, 0,            1, 0, 0,     0, 0,  0,  0,    0, 0, 0,  0,   0,             1,  0, 0, 0,  0};
        tbl[1]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0,  0,  0,    1, 0, 0,  0,   0,             0,  0, 0, 0,  0};
        tbl[2]  = '{0, 0, 0, 0,            0, 0, 0,     0, 0,  0,  0,    0, 0, 1,  5,   32'hDEADBEEF,  0,  0, 0, 0,  0};
        tbl[3]  = '{0, 1, 1, 32'h11,       1, 2, 32'h22, 0, 0, 0,  0,    0, 1, 0,  0,   0,             0,  0, 0, 0,  0};
        tbl[4]  = '{0, 1, 1, 32'h11,       1, 2, 32'h22, 0, 0, 0,  0,    1, 0, 1,  2,   32'h22,        0,  0, 0, 0,  0};
        tbl[5]  = '{0, 1, 1, 32'h11,       1, 2, 32'h22, 0, 0, 0,  0,    0, 1, 1,  1,   32'h11,        0,  0, 0, 0,  0};
        tbl[6]  = '{0, 1, 1, 32'h11,       1, 2, 32'h22, 0, 0, 0,  0,    1, 0, 1,  2,   32'h22,        0,  0, 0, 0,  0};
        tbl[7]  = '{0, 0, 0, 0,            0, 0, 0,     0, 0,  0,  0,    0, 0, 1,  1,   32'h11,        0,  0, 0, 0,  0};
        tbl[8]  = '{0, 0, 0, 0,            0, 0, 0,     1, 7,  7,  8,    0, 0, 0,  0,   0,             0,  0, 0, 0,  0};
        tbl[9]  = '{0, 0, 0, 0,            0, 0, 0,     0, 0,  7,  8,    0, 0, 0,  0,   0,             0,  1, 0, 0,  0};
        tbl[10] = '{0, 1, 7, 32'h77,       0, 0, 0,     0, 0,  7,  0,    1, 0, 0,  0,   0,             0,  1, 0, 0,  0};
        tbl[11] = '{0, 0, 0, 0,            0, 0, 0,     0, 0,  7,  0,    0, 0, 1,  7,   32'h77,        0,  1, 0, 0,  0};
        tbl[12] = '{0, 0, 0, 0,            0, 0, 0,     0, 0,  7,  0,    0, 0, 0,  0,   0,             0,  0, 0, 0,  0};
        tbl[13] = '{0, 1, 0, 32'h1,        0, 0, 0,     0, 0,  0,  0,    1, 0, 0,  0,   0,             0,  0, 0, 0,  0};
        tbl[14] = '{0, 1, 40, 32'h2,       0, 0, 0,     0, 0,  0,  0,    1, 0, 0,  0,   0,             0,  0, 0, 0,  0};
        tbl[15] = '{0, 0, 0, 0,            0, 0, 0,     0, 0,  0,  0,    0, 0, 0,  0,   0,             0,  0, 0, 1,  0};
        tbl[16] = '{0, 0, 0, 0,            0, 0, 0,     1, 3,  3,  0,    0, 0, 0,  0,   0,             0,  0, 0, 1,  0};
        tbl[17] = '{0, 0, 0, 0,            0, 0, 0,     1, 3,  3,  0,    0, 0, 0,  0,   0,             0,  1, 0, 1,  0};
        tbl[18] = '{0, 0, 0, 0,            0, 0, 0,     1, 3,  3,  0,    0, 0, 0,  0,   0,             0,  1, 0, 1,  0};
        tbl[19] = '{0, 0, 0, 0,            0, 0, 0,     1, 3,  3,  0,    0, 0, 0,  0,   0,             0,  1, 0, 1,  0};
        tbl[20] = '{0, 1, 3, 32'h33,       0, 0, 0,     0, 0,  3,  0,    1, 0, 0,  0,   0,             0,  1, 0, 1,  1};
        tbl[21] = '{0, 1, 3, 32'h34,       0, 0, 0,     1, 3,  3,  0,    1, 0, 1,  3,   32'h33,        0,  1, 0, 1,  1};
        tbl[22] = '{0, 1, 3, 32'h35,       0, 0, 0,     0, 0,  3,  0,    1, 0, 1,  3,   32'h34,        0,  1, 0, 1,  1};
        tbl[23] = '{0, 1, 3, 32'h36,       0, 0, 0,     0, 0,  3,  0,    1, 0, 1,  3,   32'h35,        0,  1, 0, 1,  1};
        tbl[24] = '{0, 0, 0, 0,            0, 0, 0,     0, 0,  3,  0,    0, 0, 1,  3,   32'h36,        0,  1, 0, 1,  1};
        tbl[25] = '{0, 0, 0, 0,            0, 0, 0,     0, 0,  3,  0,    0, 0, 0,  0,   0,             0,  0, 0, 1,  1};
        tbl[26] = '{0, 1, 12, 32'hC,       1, 9, 32'h99, 1, 10, 10, 0,   0, 1, 0,  0,   0,             0,  0, 0, 1,  1};
        tbl[27] = '{1, 1, 12, 32'hC,       1, 9, 32'h99, 0, 0, 10,  9,   0, 0, 1,  9,   32'h99,        0,  1, 0, 1,  1};
        tbl[28] = '{0, 0, 0, 0,            0, 0, 0,     0, 0, 10,  9,    0, 0, 0,  0,   0,             1,  0, 0, 0,  0};
        tbl[29] = '{0, 1, 1, 32'h5,        1, 2, 32'h6, 0, 0,  0,  0,    0, 1, 0,  0,   0,             0,  0, 0, 0,  0};
        tbl[30] = '{0, 0, 0, 0,            0, 0, 0,     0, 0,  0,  0,    0, 0, 1,  2,   32'h6,         0,  0, 0, 0,  0};

        model_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();

        for (int k = 0; k < 31; k++) begin
            apply(tbl[k]);
            #3;
            check($sformatf("v%0d_alu_ready", k), 32'(alu_ready), tbl[k].e_ar);
            check($sformatf("v%0d_lsu_ready", k), 32'(lsu_ready), tbl[k].e_lr);
            check($sformatf("v%0d_wb_en", k), 32'(wb_write_en), tbl[k].e_wen);
            if (tbl[k].e_wen != 0 || tbl[k].e_chk != 0) begin
                check($sformatf("v%0d_wb_reg", k), 32'(wb_reg_num), tbl[k].e_wreg);
                check($sformatf("v%0d_wb_data", k), wb_data, tbl[k].e_wdata);
            end
            check($sformatf("v%0d_rs1_busy", k), 32'(rs1_busy), tbl[k].e_b1);
            check($sformatf("v%0d_rs2_busy", k), 32'(rs2_busy), tbl[k].e_b2);
            check($sformatf("v%0d_err_bad", k), 32'(err_bad_reg), tbl[k].e_bad);
            check($sformatf("v%0d_err_ovf", k), 32'(err_overflow), tbl[k].e_ovf);
            model_check($sformatf("v%0d_model", k));
            tick();
        end

        // Uncontended grants must not move the pointer: after row 29 the tie
        // goes to ALU, and single-source cycles in between leave that alone.
        drive_idle();
        lsu_valid = 1'b1; lsu_rd = 6'd4; lsu_data = 32'h44;
        #3;
        check("hs_lsu_only", 32'(lsu_ready), 32'd1);
        model_check("hs0");
        tick();
        drive_idle();
        alu_valid = 1'b1; alu_rd = 6'd6; alu_data = 32'h66;
        #3;
        check("hs_alu_only", 32'(alu_ready), 32'd1);
        check("hs_lsu_wb_reg", 32'(wb_reg_num), 32'd4);
        model_check("hs1");
        tick();
        alu_valid = 1'b1; lsu_valid = 1'b1; lsu_rd = 6'd8; lsu_data = 32'h88;
        #3;
        check("hs_tie_alu_ready", 32'(alu_ready), 32'd1);
        check("hs_tie_lsu_ready", 32'(lsu_ready), 32'd0);
        model_check("hs2");
        tick();

        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            alu_valid = $urandom_range(0, 2) != 0;
            lsu_valid = $urandom_range(0, 2) != 0;
            alu_rd = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            lsu_rd = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            alu_data = $urandom;
            lsu_data = $urandom;
            issue_valid = $urandom_range(0, 2) == 0;
            issue_rd = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            rs1_num = 6'($urandom_range(0, 9));
            rs2_num = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
            #3;
            model_check($sformatf("rnd%0d", c));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter REG_FILE_SIZE, default 32, number of architectural registers.
REQ-002 SHALL have parameter XLEN, default 32, result data width.
REQ-003 SHALL have one clock, clk; reset is synchronous and active-high.
REQ-004 SHALL have ports, one per line (name direction width meaning):
 clk  in  1  clock, all state on posedge
 rst  in  1  synchronous active-high reset
 alu_valid  in  1  ALU result offered
 alu_ready  out  1  ALU result accepted this cycle
 alu_rd  in  6  ALU destination register
 alu_data  in  XLEN  ALU result
 lsu_valid  in  1  load result offered
 lsu_ready  out  1  load result accepted this cycle
 lsu_rd  in  6  load destination register
 lsu_data  in  XLEN  load result
 issue_valid  in  1  instruction issued that will write issue_rd
 issue_rd  in  6  destination of issued instruction
 rs1_num  in  6  hazard query, source 1
 rs2_num  in  6  hazard query, source 2
 rs1_busy  out  1  rs1_num has a pending write
 rs2_busy  out  1  rs2_num has a pending write
 wb_write_en  out  1  register file write enable
 wb_reg_num  out  6  register file write index
 wb_data  out  XLEN  register file write data
 err_bad_reg  out  1  sticky: out-of-range rd seen
 err_overflow  out  1  sticky: pending counter overflow

Function
REQ-005 SHALL accept a source's result when its valid and ready are both high on a clock edge.
REQ-006 SHALL drive alu_ready/lsu_ready combinationally from the valids and the round-robin pointer only; no combinational path from any other input.
REQ-007 SHALL, with one source valid, grant that source.
REQ-008 SHALL, with both valid, grant the source not granted at the last contended cycle; the first contention after reset grants LSU; the pointer flips only on contended cycles.
REQ-009 SHALL register the accepted result: wb_write_en, wb_reg_num, wb_data are valid exactly 1 cycle after acceptance; wb_write_en is low on cycles following no acceptance.
REQ-010 SHALL accept but not write (wb_write_en low) a result with rd = 0.
REQ-011 SHALL accept but not write a result with rd >= REG_FILE_SIZE, and set err_bad_reg, held until reset.
REQ-012 SHALL keep a 2-bit pending counter per register 1..REG_FILE_SIZE-1; register 0 has none.
REQ-013 SHALL increment counter[issue_rd] on an edge with issue_valid high, rd nonzero and in range.
REQ-014 SHALL decrement counter[wb_reg_num] on an edge with wb_write_en high.
REQ-015 SHALL leave a counter unchanged when increment and decrement hit it on the same edge.
REQ-016 SHALL, on increment of a counter at 3, hold it at 3 and set err_overflow, held until reset; decrement at 0 holds 0.
REQ-017 SHALL drive rsN_busy = (counter[rsN_num] != 0), combinationally; 0 for register 0 or out-of-range numbers.
REQ-018 SHALL ensure busy clears on the same edge the register file absorbs the write, so a read after busy drops sees new data.

Reset
REQ-019 SHALL, on rst high at an edge, clear all counters, wb_write_en, wb_reg_num, wb_data, err flags, and set the pointer to favour LSU.
REQ-020 SHALL drop any result registered before reset; rst takes precedence over any simultaneous acceptance or issue.
REQ-021 SHALL hold alu_ready and lsu_ready low while rst is high.

Structure
REQ-022 SHALL take XLEN, register-number width (6), and the source-select enum {SRC_ALU, SRC_LSU} from the shared core package.
REQ-023 SHALL place the pending-counter array and busy lookup in one sub-module, wb_scoreboard.

Verification
REQ-024 Only alu_valid, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1; next cycle wb_write_en=1, wb_reg_num=5, wb_data=0xDEADBEEF.
REQ-025 Both valid for 4 cycles after reset -> grants LSU, ALU, LSU, ALU; the loser's ready is low in each cycle.
REQ-026 issue_rd=7, query rs1_num=7 -> rs1_busy=1 until the edge closing the wb_write_en cycle for reg 7, then 0.
REQ-027 alu_rd=0 and alu_rd=40 accepted -> wb_write_en stays 0; err_bad_reg=1 only after the rd=40 case.
REQ-028 Four issues to reg 3 with no writeback -> counter holds 3, err_overflow=1; issue and writeback to reg 3 on the same edge leave the counter unchanged.
REQ-029 rst during an in-flight write -> next cycle wb_write_en=0, all busy=0, both readies low while rst is high.
